// File: rtl/frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tx_scheduler
//  Description : Sequences one frame_assembler per OFDM burst: loads payload
//                bytes, waits for the assembled frame, plays it out at the
//                sample rate, re-arms the assembler and idles for a gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_scheduler #(
  parameter int FRAME_LEN    = 1120,
  parameter int DATA_LEN     = 640,
  parameter int RATE_DIV     = 4,
  parameter int READ_LAT     = 2,
  parameter int GAP_CYCLES   = 16,
  parameter int WAIT_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  asm_din,
  output logic        asm_wren,
  input  logic        asm_full,
  output logic [10:0] asm_read_ptr,
  input  logic [7:0]  asm_dout,
  output logic        asm_tx_done,
  output logic [7:0]  tx_sample,
  output logic        tx_valid,
  output logic        busy,
  output logic        err,
  output logic [15:0] frame_count
);

  localparam int IN_W   = $clog2(DATA_LEN + 1);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int RATE_W = 8;
  localparam int PTR_W  = 11;
  localparam int GAP_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_ASM = 3'd2,
    S_PLAY     = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5,
    S_GAP      = 3'd6
  } state_t;

  state_t                state_q,     state_d;
  logic [IN_W-1:0]       in_cnt_q,    in_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q,  wait_cnt_d;
  logic [RATE_W-1:0]     rate_q,      rate_d;
  logic [PTR_W-1:0]      ptr_q,       ptr_d;
  logic [READ_LAT-1:0]   sr_q,        sr_d;
  logic [GAP_W-1:0]      gap_q,       gap_d;
  logic [7:0]            tx_sample_q, tx_sample_d;
  logic                  tx_valid_q,  tx_valid_d;
  logic                  tx_done_q,   tx_done_d;
  logic                  err_q,       err_d;
  logic                  to_q,        to_d;    // current frame timed out
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  launch;                // a new pointer value is presented

  // Input side is a pure pass-through gated by the LOAD state.
  assign s_ready      = (state_q == S_LOAD);
  assign asm_din      = s_data;
  assign asm_wren     = s_valid & s_ready;
  assign asm_read_ptr = ptr_q;
  assign asm_tx_done  = tx_done_q;
  assign tx_sample    = tx_sample_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign frame_count  = frame_cnt_q;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rate_d      = rate_q;
    ptr_d       = ptr_q;
    gap_d       = gap_q;
    err_d       = err_q;
    to_d        = to_q;
    frame_cnt_d = frame_cnt_q;
    launch      = 1'b0;
    // A strobe leaving the delay line marks asm_dout as valid for capture.
    tx_valid_d  = sr_q[READ_LAT-1];
    tx_sample_d = sr_q[READ_LAT-1] ? asm_dout : tx_sample_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_LOAD;
          err_d    = 1'b0;
          in_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          in_cnt_d = in_cnt_q + IN_W'(1);
          if (in_cnt_q == IN_W'(DATA_LEN - 1)) begin
            state_d    = S_WAIT_ASM;
            wait_cnt_d = '0;
          end
        end
      end
      S_WAIT_ASM: begin
        if (asm_full) begin
          state_d = S_PLAY;
          ptr_d   = '0;
          rate_d  = '0;
          launch  = 1'b1;
        end else if (wait_cnt_q == WAIT_W'(WAIT_TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_PLAY: begin
        // asm_full is deliberately ignored here; playback always completes.
        if (rate_q == RATE_W'(RATE_DIV - 1)) begin
          rate_d = '0;
          if (ptr_q == PTR_W'(FRAME_LEN - 1)) begin
            state_d = S_DRAIN;
          end else begin
            ptr_d  = ptr_q + PTR_W'(1);
            launch = 1'b1;
          end
        end else begin
          rate_d = rate_q + RATE_W'(1);
        end
      end
      S_DRAIN: begin
        if (sr_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (!to_q) frame_cnt_d = frame_cnt_q + 16'd1;
        to_d    = 1'b0;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        // A zero gap still spends one cycle here.
        if (({1'b0, gap_q} + 17'd1) >= 17'(GAP_CYCLES)) begin
          state_d  = enable ? S_LOAD : S_IDLE;
          in_cnt_d = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    sr_d[0] = launch;
    for (int i = 1; i < READ_LAT; i++) sr_d[i] = sr_q[i-1];

    tx_done_d = (state_d == S_DONE);
  end

  // State and output registers; reset holds the assembler cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      rate_q      <= '0;
      ptr_q       <= '0;
      sr_q        <= '0;
      gap_q       <= '0;
      tx_sample_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_done_q   <= 1'b1;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rate_q      <= rate_d;
      ptr_q       <= ptr_d;
      sr_q        <= sr_d;
      gap_q       <= gap_d;
      tx_sample_q <= tx_sample_d;
      tx_valid_q  <= tx_valid_d;
      tx_done_q   <= tx_done_d;
      err_q       <= err_d;
      to_q        <= to_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_tx_scheduler
//  Description : Directed bench for frame_tx_scheduler with a behavioural
//                assembler and queue-based scoreboards for bytes and samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_tx_scheduler;

  localparam int FRAME_LEN = 1120;
  localparam int DATA_LEN  = 640;
  localparam int RATE_DIV  = 4;
  localparam int READ_LAT  = 2;
  localparam int GAP_CYC   = 16;
  localparam int WAIT_TO   = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  asm_din;
  logic        asm_wren;
  logic        asm_full = 1'b0;
  logic [10:0] asm_read_ptr;
  logic [7:0]  asm_dout = 8'h00;
  logic        asm_tx_done;
  logic [7:0]  tx_sample;
  logic        tx_valid;
  logic        busy;
  logic        err;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int sample_count = 0;
  int last_wr_cyc = -1;
  int last_tx_cyc = -1;
  int full_cyc = -1;
  int done_cyc = -1;
  bit done_seen = 1'b0;
  bit last_xfer = 1'b0;
  bit full_prev = 1'b0;
  bit mon_en = 1'b0;
  bit full_en = 1'b1;
  logic [7:0] exp_in[$];
  logic [7:0] samp_q[$];

  // assembler model state
  int mdl_wr_cnt = 0;

  frame_tx_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .asm_din      (asm_din),
    .asm_wren     (asm_wren),
    .asm_full     (asm_full),
    .asm_read_ptr (asm_read_ptr),
    .asm_dout     (asm_dout),
    .asm_tx_done  (asm_tx_done),
    .tx_sample    (tx_sample),
    .tx_valid     (tx_valid),
    .busy         (busy),
    .err          (err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Assembler model: full one cycle after the last byte, dout = ptr[7:0].
  always @(posedge clk) begin
    if (asm_tx_done === 1'b1) begin
      mdl_wr_cnt <= 0;
      asm_full   <= 1'b0;
    end else begin
      if (asm_wren === 1'b1) mdl_wr_cnt <= mdl_wr_cnt + 1;
      asm_full <= full_en && (mdl_wr_cnt == DATA_LEN);
    end
    asm_dout <= asm_read_ptr[7:0];
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, return 1 time unit after rising edge.
  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      check("wren_gate", 32'(asm_wren), 32'(s_valid & s_ready));
      last_xfer = s_valid & s_ready;
      if (asm_wren) begin
        if (exp_in.size() != 0) check("asm_din", 32'(asm_din), 32'(exp_in.pop_front()));
        else check("extra_write", 32'(asm_wren), 32'(0));
        wr_count++;
        last_wr_cyc = cyc;
      end
      if (asm_full && !full_prev) begin
        full_cyc     = cyc;
        last_tx_cyc  = -1;
        sample_count = 0;
        for (int i = 0; i < FRAME_LEN; i++) samp_q.push_back(8'(i));
      end
      full_prev = asm_full;
      if (tx_valid) begin
        if (samp_q.size() != 0) check("tx_sample", 32'(tx_sample), 32'(samp_q.pop_front()));
        else check("extra_sample", 32'(tx_valid), 32'(0));
        if (last_tx_cyc >= 0) check("spacing", 32'(cyc - last_tx_cyc), 32'(RATE_DIV));
        else if (full_cyc >= 0) check("first_latency", 32'(cyc - full_cyc), 32'(READ_LAT + 1));
        last_tx_cyc = cyc;
        sample_count++;
      end
      if (asm_tx_done && rst_n) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offer DATA_LEN bytes (optionally with s_valid toggling), then one extra.
  task automatic send_frame(input bit toggle);
    int idx = 0;
    int guard = 0;
    logic [7:0] cur;
    wr_count = 0;
    cur = 8'h00;
    exp_in.push_back(cur);
    s_valid = 1'b1;
    s_data  = cur;
    while (idx < DATA_LEN && guard < 5000) begin
      tick();
      guard++;
      if (last_xfer) begin
        idx++;
        if (idx < DATA_LEN) begin
          cur = 8'(idx);
          exp_in.push_back(cur);
        end
      end
      if (idx < DATA_LEN) begin
        s_valid = toggle ? ~s_valid : 1'b1;
        s_data  = s_valid ? cur : 8'($urandom);
      end
    end
    check("load_bytes", 32'(idx), 32'(DATA_LEN));
    s_valid = 1'b1;
    s_data  = 8'hEE;
    tick();
    check("s_ready_low", 32'(s_ready), 32'(0));
    tick();
    s_valid = 1'b0;
    check("wren_count", 32'(wr_count), 32'(DATA_LEN));
  endtask

  // Wait for the tx_done pulse; optionally drop enable at a given sample.
  task automatic wait_done(input int bound, input int drop_at);
    int g = 0;
    done_seen = 1'b0;
    while (!done_seen && g < bound) begin
      tick();
      g++;
      if (drop_at >= 0 && sample_count == drop_at) enable = 1'b0;
    end
    check("done_seen", 32'(done_seen), 32'(1));
    check("done_one_cycle", 32'(asm_tx_done), 32'(0));
  endtask

  initial begin
    int g;
    // reset state
    repeat (3) tick();
    check("rst_tx_done", 32'(asm_tx_done), 32'(1));
    check("rst_tx_valid", 32'(tx_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_count", 32'(frame_count), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_ptr", 32'(asm_read_ptr), 32'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    check("tx_done_release", 32'(asm_tx_done), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));

    // frame 1: continuous load, full playback
    enable = 1'b1;
    send_frame(1'b0);
    wait_done(6000, -1);
    check("f1_samples", 32'(sample_count), 32'(FRAME_LEN));
    check("f1_frame_count", 32'(frame_count), 32'(1));
    check("f1_err", 32'(err), 32'(0));

    // frame 2: toggled s_valid, enable dropped at sample 500
    send_frame(1'b1);
    wait_done(6000, 500);
    check("f2_samples", 32'(sample_count), 32'(FRAME_LEN));
    check("f2_frame_count", 32'(frame_count), 32'(2));
    g = 0;
    while (busy && g < 100) begin
      tick();
      g++;
    end
    check("gap_len", 32'(g), 32'(GAP_CYC));
    check("f2_idle_busy", 32'(busy), 32'(0));
    check("f2_idle_count", 32'(frame_count), 32'(2));

    // frame 3: assembler never fills -> timeout
    full_en = 1'b0;
    enable  = 1'b1;
    send_frame(1'b0);
    wait_done(5000, -1);
    check("timeout_cycles", 32'(done_cyc - last_wr_cyc), 32'(WAIT_TO + 1));
    check("timeout_err", 32'(err), 32'(1));
    check("timeout_count", 32'(frame_count), 32'(2));
    check("timeout_no_samples", 32'(samp_q.size()), 32'(0));
    enable = 1'b0;
    g = 0;
    while (busy && g < 100) begin
      tick();
      g++;
    end
    check("timeout_idle", 32'(busy), 32'(0));
    check("err_sticky", 32'(err), 32'(1));
    full_en = 1'b1;
    enable  = 1'b1;
    tick();
    check("err_cleared", 32'(err), 32'(0));
    check("restart_busy", 32'(busy), 32'(1));

    // frame 4: reset at sample 300
    send_frame(1'b0);
    g = 0;
    while (sample_count < 300 && g < 3000) begin
      tick();
      g++;
    end
    check("reach_300", 32'(sample_count), 32'(300));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'(0));
    check("mid_rst_tx_done", 32'(asm_tx_done), 32'(1));
    check("mid_rst_count", 32'(frame_count), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    samp_q.delete();
    exp_in.delete();
    full_cyc    = -1;
    last_tx_cyc = -1;

    // frame 5: restart after reset, loads from byte 0
    send_frame(1'b0);
    wait_done(6000, -1);
    check("f5_samples", 32'(sample_count), 32'(FRAME_LEN));
    check("f5_frame_count", 32'(frame_count), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_tx_scheduler.md
Name: frame_tx_scheduler

Overview:
Sequences one frame_assembler instance per OFDM burst:
- streams 640 payload bytes into its input side;
- waits for its output-buffer-full flag;
- sweeps its read pointer 0..FRAME_LEN-1 at the DAC/LED sample rate;
- pulses tx_done to re-arm it, then waits an inter-frame gap.

It sits between the upstream symbol source (IFFT+CP stream) and the assembler, and produces the paced sample stream for the optical front end.

Parameters:
FRAME_LEN, 1120, total assembled samples per frame (480 preamble + 640 data).
DATA_LEN, 640, payload bytes written per frame ((64+16)*8).
RATE_DIV, 4, clk cycles per output sample; legal range 1..255.
READ_LAT, 2, cycles from asm_read_ptr change to valid asm_dout; legal range 1..7.
GAP_CYCLES, 16, idle cycles between frames; legal range 0..65535.
WAIT_TIMEOUT, 4096, maximum cycles in WAIT_ASM before abort.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  level; 1 = run frames back-to-back
s_data  in  8  upstream payload byte
s_valid  in  1  upstream byte valid
s_ready  out  1  scheduler accepts byte (valid&ready = transfer)
asm_din  out  8  to assembler din
asm_wren  out  1  to assembler wren
asm_full  in  1  assembler out_buff_full
asm_read_ptr  out  11  to assembler read_ptr
asm_dout  in  8  assembler dout
asm_tx_done  out  1  to assembler tx_done
tx_sample  out  8  paced output sample
tx_valid  out  1  one-cycle strobe per tx_sample
busy  out  1  state != IDLE
err  out  1  sticky timeout flag
frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous on rst_n low: state=IDLE, asm_tx_done=1 (clears the assembler while held), every other output register=0, all counters=0. asm_tx_done falls to 0 on the first clk edge after rst_n rises.
- States: IDLE, LOAD, WAIT_ASM, PLAY, DRAIN, DONE, GAP.
- IDLE: if enable=1 -> LOAD and clear err.
- LOAD:
  - s_ready=1 combinationally in LOAD only.
  - asm_din=s_data and asm_wren=s_valid&s_ready, combinational pass-through.
  - in_cnt increments per transfer.
  - On the transfer with in_cnt=DATA_LEN-1 -> WAIT_ASM; s_ready drops the next cycle. Byte DATA_LEN+1 is never accepted.
- WAIT_ASM:
  - Wait for asm_full=1 -> PLAY, with asm_read_ptr=0 and rate counter=0.
  - wait_cnt counts cycles. If wait_cnt reaches WAIT_TIMEOUT -> DONE with err=1; frame_count is not incremented.
- PLAY:
  - The rate counter counts 0..RATE_DIV-1. When it wraps, asm_read_ptr advances by 1.
  - Each pointer value, including 0 on PLAY entry, launches a strobe into a READ_LAT-deep shift register. When the strobe emerges, tx_sample<=asm_dout and tx_valid=1 for one cycle.
  - After the period of ptr=FRAME_LEN-1 -> DRAIN. asm_read_ptr holds FRAME_LEN-1 and never reaches FRAME_LEN.
- DRAIN: wait until the shift register is empty, i.e. the last tx_valid has been issued -> DONE.
- DONE: asm_tx_done=1 for exactly one cycle; frame_count+1 unless the frame timed out -> GAP.
- GAP: count GAP_CYCLES cycles (0 = pass-through in one cycle), then -> LOAD if enable=1, else IDLE.
- Samples per frame: exactly FRAME_LEN tx_valid pulses, spaced exactly RATE_DIV cycles apart. First pulse is READ_LAT cycles after PLAY entry.
- enable deasserted mid-frame: the current frame completes through GAP, then IDLE. No partial frames.
- asm_full dropping during PLAY: ignored, playback continues.
- s_valid outside LOAD: ignored, s_ready=0.
- rst_n low in any state: immediate return to IDLE next edge. An in-flight tx_valid is cancelled and asm_tx_done is held 1.
- asm_tx_done=0 in every state except DONE and reset.

Test Plan:
1. Reset then enable=1, continuous s_valid with bytes 0..639 mod 256 -> exactly 640 asm_wren pulses, s_ready low from cycle 641. A model asserting asm_full 1 cycle later -> PLAY entered.
2. PLAY with defaults, model returning asm_dout=ptr[7:0] after 2 cycles -> 1120 tx_valid pulses 4 cycles apart, values 0,1,..,255,0,.. ending 0x5F (1119 mod 256); then asm_tx_done pulse 1 cycle, frame_count=1.
3. Upstream s_valid toggled every other cycle -> still exactly 640 writes. No write occurs while s_ready=0 or s_valid=0.
4. asm_full never asserted -> after 4096 WAIT_ASM cycles: asm_tx_done pulse, err=1, frame_count=0. A new start via enable clears err.
5. enable dropped at sample 500 of frame 1 -> all 1120 samples emitted, 16 GAP cycles, then IDLE; busy=0, frame_count=1.
6. rst_n low for 1 cycle at sample 300 -> next cycle: state IDLE, tx_valid=0, asm_tx_done=1, frame_count=0. With enable=1 after reset, LOAD restarts with in_cnt=0.
